// File: rtl/alu_issue_stage_pkg.sv
// Shared constants and ALU control encoding for the issue stage and its register file.
package alu_issue_stage_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_N      = 16;
    localparam int ADDR_W     = 4;
    localparam int CTRL_W     = 4;
    localparam int STARVE_MAX = 4;
    localparam int STARVE_W   = $clog2(STARVE_MAX + 1);

    // Control bit that marks the arithmetic ops (ADD/SUB), the only ones that own carry.
    localparam int CARRY_BIT  = 2;

    typedef enum logic [2:0] {
        ALU_NOT = 3'b000,
        ALU_AND = 3'b001,
        ALU_SHR = 3'b010,
        ALU_XOR = 3'b011,
        ALU_ADD = 3'b100,
        ALU_SUB = 3'b101
    } alu_op_e;

endpackage

// File: rtl/alu_issue_stage_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, r0 hardwired to zero.
module alu_issue_stage_regfile
    import alu_issue_stage_pkg::*;
#(
    parameter int RF_DATA_W = DATA_W,
    parameter int RF_REG_N  = REG_N,
    parameter int RF_ADDR_W = ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_i,
    input  logic [RF_ADDR_W-1:0] waddr_i,
    input  logic [RF_DATA_W-1:0] wdata_i,
    input  logic [RF_ADDR_W-1:0] raddr1_i,
    input  logic [RF_ADDR_W-1:0] raddr2_i,
    output logic [RF_DATA_W-1:0] rdata1_o,
    output logic [RF_DATA_W-1:0] rdata2_o
);

    logic [RF_DATA_W-1:0] mem_q [RF_REG_N];

    // Storage array; writes aimed at r0 are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RF_REG_N; i++) begin
                mem_q[i] <= {RF_DATA_W{1'b0}};
            end
        end else if (we_i && (waddr_i != {RF_ADDR_W{1'b0}})) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == {RF_ADDR_W{1'b0}}) ? {RF_DATA_W{1'b0}} : mem_q[raddr1_i];
    assign rdata2_o = (raddr2_i == {RF_ADDR_W{1'b0}}) ? {RF_DATA_W{1'b0}} : mem_q[raddr2_i];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-fetch/issue stage feeding a combinational ALU: EX-slot register, operand forwarding,
// write-port arbitration between ALU write-back and an external port, starvation guard, flags.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [CTRL_W-1:0] issue_ctrl,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] issue_rs1,
    input  logic [ADDR_W-1:0] issue_rs2,
    input  logic              issue_use_imm,
    input  logic [DATA_W-1:0] issue_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_control,
    input  logic [DATA_W-1:0] alu_dout,
    input  logic              alu_cout,
    input  logic              ext_valid,
    output logic              ext_ready,
    input  logic [ADDR_W-1:0] ext_rd,
    input  logic [DATA_W-1:0] ext_data,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c,
    output logic              busy
);

    logic                op_valid_q, op_valid_d;
    logic [ADDR_W-1:0]   rd_q, rd_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                z_q, z_d;
    logic                n_q, n_d;
    logic                c_q, c_d;
    logic [STARVE_W-1:0] starve_q, starve_d;

    logic                issue_ready_s;
    logic                ext_ready_s;
    logic                issue_acc_s;
    logic                ext_acc_s;
    logic                rf_we_s;
    logic [ADDR_W-1:0]   rf_waddr_s;
    logic [DATA_W-1:0]   rf_wdata_s;
    logic [DATA_W-1:0]   rf_rdata1_s;
    logic [DATA_W-1:0]   rf_rdata2_s;

    // Youngest value wins: result in EX, then an external write landing this edge, then the file.
    function automatic logic [DATA_W-1:0] fwd_operand(
        input logic [ADDR_W-1:0] rs,
        input logic [DATA_W-1:0] rf_val,
        input logic              ex_v,
        input logic [ADDR_W-1:0] ex_rd,
        input logic [DATA_W-1:0] ex_val,
        input logic              ext_v,
        input logic [ADDR_W-1:0] ext_rd_a,
        input logic [DATA_W-1:0] ext_val
    );
        if (rs == {ADDR_W{1'b0}}) begin
            return {DATA_W{1'b0}};
        end else if (ex_v && (ex_rd == rs)) begin
            return ex_val;
        end else if (ext_v && (ext_rd_a == rs)) begin
            return ext_val;
        end else begin
            return rf_val;
        end
    endfunction

    alu_issue_stage_regfile #(
        .RF_DATA_W (DATA_W),
        .RF_REG_N  (REG_N),
        .RF_ADDR_W (ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (rf_we_s),
        .waddr_i  (rf_waddr_s),
        .wdata_i  (rf_wdata_s),
        .raddr1_i (issue_rs1),
        .raddr2_i (issue_rs2),
        .rdata1_o (rf_rdata1_s),
        .rdata2_o (rf_rdata2_s)
    );

    // Handshake readiness depends on state only; write-back owns the port whenever EX is full.
    always_comb begin
        ext_ready_s   = !op_valid_q;
        issue_ready_s = (starve_q != STARVE_W'(STARVE_MAX));
        issue_acc_s   = issue_valid && issue_ready_s;
        ext_acc_s     = ext_valid && ext_ready_s;
    end

    // Single write port: ALU write-back, else an accepted external write.
    always_comb begin
        rf_we_s    = 1'b0;
        rf_waddr_s = {ADDR_W{1'b0}};
        rf_wdata_s = {DATA_W{1'b0}};
        if (op_valid_q) begin
            rf_we_s    = 1'b1;
            rf_waddr_s = rd_q;
            rf_wdata_s = alu_dout;
        end else if (ext_acc_s) begin
            rf_we_s    = 1'b1;
            rf_waddr_s = ext_rd;
            rf_wdata_s = ext_data;
        end else begin
            rf_we_s    = 1'b0;
        end
    end

    // EX-slot next state; operands hold when nothing is accepted.
    always_comb begin
        op_valid_d = issue_acc_s;
        rd_d       = rd_q;
        ctrl_d     = ctrl_q;
        a_d        = a_q;
        b_d        = b_q;
        if (issue_acc_s) begin
            rd_d   = issue_rd;
            ctrl_d = issue_ctrl;
            a_d    = fwd_operand(issue_rs1, rf_rdata1_s, op_valid_q, rd_q, alu_dout,
                                 ext_acc_s, ext_rd, ext_data);
            if (issue_use_imm) begin
                b_d = issue_imm;
            end else begin
                b_d = fwd_operand(issue_rs2, rf_rdata2_s, op_valid_q, rd_q, alu_dout,
                                  ext_acc_s, ext_rd, ext_data);
            end
        end else begin
            op_valid_d = 1'b0;
        end
    end

    // Flags follow every write-back, including ones discarded because rd is r0.
    always_comb begin
        z_d = z_q;
        n_d = n_q;
        c_d = c_q;
        if (op_valid_q) begin
            z_d = (alu_dout == {DATA_W{1'b0}});
            n_d = alu_dout[DATA_W-1];
            if (ctrl_q[CARRY_BIT]) begin
                c_d = alu_cout;
            end else begin
                c_d = c_q;
            end
        end else begin
            c_d = c_q;
        end
    end

    // A starved external write refuses one issue on reaching the limit; the resulting bubble
    // frees the port, so the count restarts rather than holding issue off a second cycle.
    always_comb begin
        starve_d = {STARVE_W{1'b0}};
        if (ext_valid && !ext_ready_s) begin
            if (starve_q == STARVE_W'(STARVE_MAX)) begin
                starve_d = {STARVE_W{1'b0}};
            end else begin
                starve_d = starve_q + STARVE_W'(1);
            end
        end else begin
            starve_d = {STARVE_W{1'b0}};
        end
    end

    // State registers; reset discards any in-flight op and pending starvation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid_q <= 1'b0;
            rd_q       <= {ADDR_W{1'b0}};
            ctrl_q     <= {CTRL_W{1'b0}};
            a_q        <= {DATA_W{1'b0}};
            b_q        <= {DATA_W{1'b0}};
            z_q        <= 1'b0;
            n_q        <= 1'b0;
            c_q        <= 1'b0;
            starve_q   <= {STARVE_W{1'b0}};
        end else begin
            op_valid_q <= op_valid_d;
            rd_q       <= rd_d;
            ctrl_q     <= ctrl_d;
            a_q        <= a_d;
            b_q        <= b_d;
            z_q        <= z_d;
            n_q        <= n_d;
            c_q        <= c_d;
            starve_q   <= starve_d;
        end
    end

    assign issue_ready = issue_ready_s;
    assign ext_ready   = ext_ready_s;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_control = ctrl_q;
    assign flag_z      = z_q;
    assign flag_n      = n_q;
    assign flag_c      = c_q;
    assign busy        = op_valid_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench: an architectural register/flag model predicts each op's operands and flags;
// a monitor pops predictions whenever the EX slot is busy.
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              issue_valid, issue_ready, issue_use_imm;
    logic [3:0]        issue_ctrl, issue_rd, issue_rs1, issue_rs2;
    logic [31:0]       issue_imm, alu_a, alu_b, alu_dout, ext_data;
    logic [3:0]        alu_control, ext_rd;
    logic              alu_cout, ext_valid, ext_ready, flag_z, flag_n, flag_c, busy;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctl;
        logic        z;
        logic        n;
        logic        c;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] mregs [16];
    logic        pend_v;
    logic [3:0]  pend_rd;
    logic [31:0] pend_res;
    int          wait_cnt;
    logic        mz, mn, mc;
    logic        flag_chk = 1'b0;
    logic [2:0]  exp_flags;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_ctrl(issue_ctrl),
        .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_use_imm(issue_use_imm), .issue_imm(issue_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_dout(alu_dout), .alu_cout(alu_cout),
        .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_rd(ext_rd), .ext_data(ext_data),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .busy(busy)
    );

    function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] ctl);
        case (ctl[2:0])
            3'b000:  return {1'b0, ~a};
            3'b001:  return {1'b0, a & b};
            3'b010:  return {1'b0, a >> b[4:0]};
            3'b011:  return {1'b0, a ^ b};
            3'b100:  return {1'b0, a} + {1'b0, b};
            3'b101:  return {1'b0, a} + {1'b0, ~b} + 33'd1;
            default: return 33'd0;
        endcase
    endfunction

    // The bench plays the combinational ALU.
    assign {alu_cout, alu_dout} = alu_ref(alu_a, alu_b, alu_control);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mregs[i] = 32'd0;
        pend_v   = 1'b0;
        pend_rd  = 4'd0;
        pend_res = 32'd0;
        wait_cnt = 0;
        mz = 1'b0; mn = 1'b0; mc = 1'b0;
    endtask

    // One clock of stimulus; the model applies this edge's writes before reading operands.
    task automatic cycle(input logic iv, input logic [3:0] ctl, input logic [3:0] rd,
                         input logic [3:0] rs1, input logic [3:0] rs2, input logic ui,
                         input logic [31:0] imm, input logic ev, input logic [3:0] erd,
                         input logic [31:0] ed, output logic iacc, output logic eacc);
        logic [32:0] r;
        logic [31:0] a, b;
        @(negedge clk);
        chk("ext_ready", 32'(ext_ready), 32'(!pend_v));
        chk("issue_ready", 32'(issue_ready), 32'(wait_cnt < STARVE_MAX));
        issue_valid = iv; issue_ctrl = ctl; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
        issue_use_imm = ui; issue_imm = imm;
        ext_valid = ev; ext_rd = erd; ext_data = ed;
        iacc = iv && issue_ready;
        eacc = ev && ext_ready;
        if (pend_v && pend_rd != 4'd0) mregs[pend_rd] = pend_res;
        if (eacc && erd != 4'd0) mregs[erd] = ed;
        if (ev && !eacc) wait_cnt = (wait_cnt == STARVE_MAX) ? 0 : wait_cnt + 1;
        else             wait_cnt = 0;
        pend_v = iacc;
        if (iacc) begin
            a = mregs[rs1];
            b = ui ? imm : mregs[rs2];
            r = alu_ref(a, b, ctl);
            mz = (r[31:0] == 32'd0);
            mn = r[31];
            if (ctl[2]) mc = r[32];
            exp_q.push_back('{a: a, b: b, ctl: ctl, z: mz, n: mn, c: mc});
            pend_rd  = rd;
            pend_res = r[31:0];
        end
    endtask

    task automatic idle();
        logic ia, ea;
        cycle(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, ia, ea);
    endtask

    task automatic issue_op(input logic [3:0] ctl, input logic [3:0] rd, input logic [3:0] rs1,
                            input logic [3:0] rs2, input logic ui, input logic [31:0] imm);
        logic ia, ea;
        ia = 1'b0;
        for (int t = 0; t < 10 && !ia; t++)
            cycle(1'b1, ctl, rd, rs1, rs2, ui, imm, 1'b0, 4'd0, 32'd0, ia, ea);
        if (!ia) begin
            n_cmp++; n_mis++;
            $display("FAIL issue_timeout: op never accepted, got 0 expected 1");
        end
    endtask

    // Monitor: every busy cycle consumes one prediction; flags are checked after its write-back.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (flag_chk) begin
                    chk("flags_znc", {29'd0, flag_z, flag_n, flag_c}, {29'd0, exp_flags});
                    flag_chk = 1'b0;
                end
                if (busy === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_mis++;
                        $display("FAIL unexpected_busy: got busy=1 expected 0 at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("alu_a", alu_a, e.a);
                        chk("alu_b", alu_b, e.b);
                        chk("alu_control", 32'(alu_control), 32'(e.ctl));
                        exp_flags = {e.z, e.n, e.c};
                        flag_chk  = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        logic ia, ea;
        int   acc_at, bubbles;
        rst_n = 1'b0;
        issue_valid = 1'b0; issue_ctrl = 4'd0; issue_rd = 4'd0; issue_rs1 = 4'd0;
        issue_rs2 = 4'd0; issue_use_imm = 1'b0; issue_imm = 32'd0;
        ext_valid = 1'b0; ext_rd = 4'd0; ext_data = 32'd0;
        model_reset();
        #1;
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_ctrl", 32'(alu_control), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", {29'd0, flag_z, flag_n, flag_c}, 32'd0);
        chk("rst_issue_ready", 32'(issue_ready), 32'd1);
        chk("rst_ext_ready", 32'(ext_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Forwarded ADD->SUB chain, then carry set by ADD and held through XOR.
        issue_op(4'd4, 4'd1, 4'd0, 4'd0, 1'b1, 32'd5);
        issue_op(4'd5, 4'd2, 4'd1, 4'd0, 1'b1, 32'd7);
        issue_op(4'd4, 4'd4, 4'd2, 4'd0, 1'b1, 32'd3);
        issue_op(4'd3, 4'd3, 4'd2, 4'd2, 1'b0, 32'd0);
        issue_op(4'd4, 4'd7, 4'd3, 4'd2, 1'b0, 32'd0);

        // External write and issue read of the same register on the same edge.
        idle();
        cycle(1'b1, 4'd4, 4'd8, 4'd6, 4'd0, 1'b1, 32'd1, 1'b1, 4'd6, 32'h1234_5678, ia, ea);
        chk("same_edge_ext_acc", 32'(ea), 32'd1);
        chk("same_edge_issue_acc", 32'(ia), 32'd1);

        // Writes to r0 from both ports are dropped; flags still follow the ALU result.
        issue_op(4'd4, 4'd0, 4'd1, 4'd0, 1'b1, 32'h7FFF_FFFB);
        idle();
        cycle(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0, 1'b1, 4'd0, 32'hDEAD_BEEF, ia, ea);
        issue_op(4'd4, 4'd9, 4'd0, 4'd0, 1'b0, 32'd0);

        // Continuous issue starving an external write.
        issue_op(4'd4, 4'd12, 4'd12, 4'd0, 1'b1, 32'd1);
        issue_op(4'd4, 4'd12, 4'd12, 4'd0, 1'b1, 32'd1);
        acc_at = -1; bubbles = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 4'd4, 4'd12, 4'd12, 4'd0, 1'b1, 32'd1, 1'b1, 4'd5, 32'hA5A5_A5A5, ia, ea);
            if (!ia) bubbles++;
            if (ea) begin
                acc_at = k;
                break;
            end
        end
        chk("starve_accept_cycle", 32'(acc_at), 32'(STARVE_MAX + 1));
        chk("starve_bubbles", 32'(bubbles), 32'd1);
        issue_op(4'd4, 4'd13, 4'd5, 4'd0, 1'b1, 32'd0);

        // Reset with an op in EX: no write-back, everything back to zero at once.
        issue_op(4'd4, 4'd10, 4'd0, 4'd0, 1'b1, 32'd99);
        @(negedge clk);
        issue_valid = 1'b0; ext_valid = 1'b1; ext_rd = 4'd11; ext_data = 32'h5555_0000;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_alu_a", alu_a, 32'd0);
        chk("midrst_alu_b", alu_b, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_flags", {29'd0, flag_z, flag_n, flag_c}, 32'd0);
        exp_q.delete();
        flag_chk = 1'b0;
        model_reset();
        ext_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        issue_op(4'd4, 4'd14, 4'd10, 4'd11, 1'b0, 32'd0);
        issue_op(4'd4, 4'd14, 4'd1, 4'd2, 1'b0, 32'd0);

        // Randomized traffic over a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 8), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                  4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
                  ($urandom_range(0, 9) < 3), 4'($urandom_range(0, 7)), $urandom, ia, ea);
        end

        repeat (3) idle();
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
